// File: rtl/fir_channel_scheduler_pkg.sv
// Shared types and defaults for the FIR channel scheduler.
package fir_channel_scheduler_pkg;

  localparam int DEFAULT_NUM_CH     = 4;
  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_TIMEOUT    = 256;

  // One-hot scheduler states.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_ISSUE   = 4'b0010,
    ST_WAIT    = 4'b0100,
    ST_DELIVER = 4'b1000
  } sched_state_e;

  // The watchdog counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT)
  // bits suffice. A disabled (0) or trivial (1) limit still gets one bit.
  function automatic int wdog_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at the channel
// after last_grant and wraps, so every requester is served in turn.
module fir_channel_scheduler_rr_arbiter
  import fir_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH   = DEFAULT_NUM_CH,
  parameter int CH_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_WIDTH-1:0] last_grant,
  output logic [CH_WIDTH-1:0] grant,
  output logic                any_req
);

  // Candidate gi is the channel gi+1 positions after last_grant.
  logic [CH_WIDTH-1:0] cand_idx [NUM_CH];
  logic [NUM_CH-1:0]   cand_req;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    logic [CH_WIDTH:0] sum;
    // last_grant <= NUM_CH-1, so one conditional subtract is a full modulo.
    assign sum = {1'b0, last_grant} + (CH_WIDTH+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (CH_WIDTH+1)'(NUM_CH))
                        ? CH_WIDTH'(sum - (CH_WIDTH+1)'(NUM_CH))
                        : sum[CH_WIDTH-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Pick the nearest requesting candidate; scanning from the far end lets
  // the closest one overwrite the others.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand_req[i]) grant = cand_idx[i];
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR datapath among NUM_CH requesters: round-robin grant,
// sample issue, result wait, tagged delivery, and a stall watchdog.
module fir_channel_scheduler
  import fir_channel_scheduler_pkg::*;
#(
  parameter  int NUM_CH     = DEFAULT_NUM_CH,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int CH_WIDTH   = $clog2(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_din,
  input  logic [NUM_CH-1:0]            iv_ch_valid,
  output logic [NUM_CH-1:0]            ov_ch_ready,
  output logic [DATA_WIDTH-1:0]        ov_fir_din,
  output logic [CH_WIDTH-1:0]          ov_fir_ch,
  output logic                         o_fir_din_valid,
  input  logic                         i_fir_ready,
  input  logic [DATA_WIDTH-1:0]        iv_fir_dout,
  input  logic                         i_fir_dout_valid,
  output logic                         o_fir_ready,
  output logic                         o_fir_rst,
  output logic [DATA_WIDTH-1:0]        ov_dout,
  output logic [CH_WIDTH-1:0]          ov_dout_ch,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready,
  output logic                         o_err
);

  localparam int WD_W = wdog_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  sched_state_e        state_reg;
  logic [CH_WIDTH-1:0] last_grant_reg;
  logic [WD_W-1:0]     wdog_cnt_reg;

  logic [CH_WIDTH-1:0]   arb_grant;
  logic                  arb_any;
  logic [NUM_CH-1:0]     grant_onehot;
  logic [DATA_WIDTH-1:0] ch_sample [NUM_CH];
  logic                  wdog_expired;

  // Unpack the flattened sample bus and build the one-hot ready pattern.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_sample[gi]    = iv_ch_din[gi*DATA_WIDTH +: DATA_WIDTH];
    assign grant_onehot[gi] = (arb_grant == CH_WIDTH'(gi));
  end

  // A zero limit turns the watchdog off entirely.
  assign wdog_expired = (TIMEOUT != 0) && (wdog_cnt_reg == WD_LAST);

  fir_channel_scheduler_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_arb (
    .req        (iv_ch_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Scheduler FSM; every output is a register so the filter and the
  // requesters never see combinational paths through the arbiter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= ST_IDLE;
      last_grant_reg  <= CH_WIDTH'(NUM_CH - 1);
      wdog_cnt_reg    <= '0;
      ov_ch_ready     <= '0;
      ov_fir_din      <= '0;
      ov_fir_ch       <= '0;
      o_fir_din_valid <= 1'b0;
      o_fir_ready     <= 1'b0;
      o_fir_rst       <= 1'b0;
      ov_dout         <= '0;
      ov_dout_ch      <= '0;
      o_dout_valid    <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state sets them this cycle.
      ov_ch_ready <= '0;
      o_fir_ready <= 1'b0;
      o_fir_rst   <= 1'b0;
      o_err       <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            ov_ch_ready     <= grant_onehot;
            ov_fir_din      <= ch_sample[arb_grant];
            ov_fir_ch       <= arb_grant;
            o_fir_din_valid <= 1'b1;
            wdog_cnt_reg    <= '0;
            state_reg       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Expiry is checked first so the counter never runs past WD_LAST.
          if (wdog_expired) begin
            o_fir_din_valid <= 1'b0;
            o_err           <= 1'b1;
            o_fir_rst       <= 1'b1;
            last_grant_reg  <= ov_fir_ch;
            state_reg       <= ST_IDLE;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            if (i_fir_ready) begin
              o_fir_din_valid <= 1'b0;
              state_reg       <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // A result arriving on the expiry cycle still counts as success.
          if (i_fir_dout_valid) begin
            ov_dout      <= iv_fir_dout;
            ov_dout_ch   <= ov_fir_ch;
            o_fir_ready  <= 1'b1;
            o_dout_valid <= 1'b1;
            state_reg    <= ST_DELIVER;
          end else if (wdog_expired) begin
            o_err          <= 1'b1;
            o_fir_rst      <= 1'b1;
            last_grant_reg <= ov_fir_ch;
            state_reg      <= ST_IDLE;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
          end
        end

        ST_DELIVER: begin
          // Downstream backpressure may hold us here indefinitely; no watchdog.
          if (i_dout_ready) begin
            o_dout_valid   <= 1'b0;
            last_grant_reg <= ov_fir_ch;
            state_reg      <= ST_IDLE;
          end
        end

        default: begin
          o_fir_din_valid <= 1'b0;
          o_dout_valid    <= 1'b0;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: a table of round-robin
// transactions followed by hand-written backpressure, watchdog and reset cases.
module tb_fir_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int DW     = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH*DW-1:0] ch_din;
  logic [NUM_CH-1:0] ch_valid;
  logic              fir_ready_in;
  logic [DW-1:0]     fir_dout;
  logic              fir_dout_valid;
  logic              dout_ready;

  // Main instance outputs
  logic [NUM_CH-1:0] ch_ready;
  logic [DW-1:0]     fir_din;
  logic [1:0]        fir_ch;
  logic              fir_din_valid;
  logic              fir_ready_out;
  logic              fir_rst;
  logic [DW-1:0]     dout;
  logic [1:0]        dout_ch;
  logic              dout_valid;
  logic              err;

  // Short-watchdog instance outputs
  logic [NUM_CH-1:0] wd_ch_ready;
  logic [DW-1:0]     wd_fir_din;
  logic [1:0]        wd_fir_ch;
  logic              wd_fir_din_valid;
  logic              wd_fir_ready;
  logic              wd_fir_rst;
  logic [DW-1:0]     wd_dout;
  logic [1:0]        wd_dout_ch;
  logic              wd_dout_valid;
  logic              wd_err;

  logic [DW-1:0] samples [NUM_CH];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TIMEOUT(256)) dut (
    .i_clk(clk), .i_rst(rst), .iv_ch_din(ch_din), .iv_ch_valid(ch_valid),
    .ov_ch_ready(ch_ready), .ov_fir_din(fir_din), .ov_fir_ch(fir_ch),
    .o_fir_din_valid(fir_din_valid), .i_fir_ready(fir_ready_in),
    .iv_fir_dout(fir_dout), .i_fir_dout_valid(fir_dout_valid),
    .o_fir_ready(fir_ready_out), .o_fir_rst(fir_rst), .ov_dout(dout),
    .ov_dout_ch(dout_ch), .o_dout_valid(dout_valid), .i_dout_ready(dout_ready),
    .o_err(err)
  );

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TIMEOUT(16)) dut_wd (
    .i_clk(clk), .i_rst(rst), .iv_ch_din(ch_din), .iv_ch_valid(ch_valid),
    .ov_ch_ready(wd_ch_ready), .ov_fir_din(wd_fir_din), .ov_fir_ch(wd_fir_ch),
    .o_fir_din_valid(wd_fir_din_valid), .i_fir_ready(fir_ready_in),
    .iv_fir_dout(fir_dout), .i_fir_dout_valid(fir_dout_valid),
    .o_fir_ready(wd_fir_ready), .o_fir_rst(wd_fir_rst), .ov_dout(wd_dout),
    .ov_dout_ch(wd_dout_ch), .o_dout_valid(wd_dout_valid), .i_dout_ready(dout_ready),
    .o_err(wd_err)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  exp_ch;
    logic [23:0] result;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_valid = '0;
    fir_ready_in = 1'b0;
    fir_dout = '0;
    fir_dout_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request mask and check the grant that follows one cycle later.
  task automatic start_grant(input logic [3:0] vmask, input logic [1:0] exp_ch, input string tag);
    int n;
    logic [3:0] exp_ready;
    ch_valid = vmask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_ready == 4'b0 && n < 8);
    exp_ready = 4'b0001 << exp_ch;
    check({tag, " grant latency"}, n, 1);
    check({tag, " ch_ready"}, ch_ready, exp_ready);
    check({tag, " fir_din_valid"}, fir_din_valid, 1);
    check({tag, " fir_din"}, fir_din, samples[exp_ch]);
    check({tag, " fir_ch"}, fir_ch, exp_ch);
    @(negedge clk);
    check({tag, " ready pulse width"}, ch_ready, 0);
    check({tag, " din_valid held"}, fir_din_valid, 1);
  endtask

  // Filter consumes the sample, then returns res after lat idle cycles.
  task automatic feed_filter(input logic [23:0] res, input int lat, input logic [1:0] exp_ch, input string tag);
    fir_ready_in = 1'b1;
    @(negedge clk);
    fir_ready_in = 1'b0;
    check({tag, " din_valid drop"}, fir_din_valid, 0);
    repeat (lat) @(negedge clk);
    fir_dout = res;
    fir_dout_valid = 1'b1;
    @(negedge clk);
    fir_dout_valid = 1'b0;
    check({tag, " fir_ready pulse"}, fir_ready_out, 1);
    check({tag, " dout_valid"}, dout_valid, 1);
    check({tag, " dout"}, dout, res);
    check({tag, " dout_ch"}, dout_ch, exp_ch);
    @(negedge clk);
    check({tag, " fir_ready width"}, fir_ready_out, 0);
    check({tag, " dout_valid held"}, dout_valid, 1);
  endtask

  task automatic finish_txn(input string tag);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check({tag, " dout_valid drop"}, dout_valid, 0);
    $display("txn %s ch=%0d dout=0x%06h", tag, dout_ch, dout);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    samples[0] = 24'h00A000;
    samples[1] = 24'h00B111;
    samples[2] = 24'h000123;
    samples[3] = 24'h00D333;
    for (int k = 0; k < NUM_CH; k++) ch_din[k*DW +: DW] = samples[k];

    vecs[0]  = '{4'b1111, 2'd0, 24'h111111, 2};
    vecs[1]  = '{4'b1111, 2'd1, 24'h222222, 0};
    vecs[2]  = '{4'b1111, 2'd2, 24'h333333, 5};
    vecs[3]  = '{4'b1111, 2'd3, 24'h444444, 1};
    vecs[4]  = '{4'b1111, 2'd0, 24'h555555, 3};
    vecs[5]  = '{4'b0100, 2'd2, 24'h000456, 20};
    vecs[6]  = '{4'b1000, 2'd3, 24'hABCDEF, 1};
    vecs[7]  = '{4'b1001, 2'd0, 24'h00FF00, 2};
    vecs[8]  = '{4'b1001, 2'd3, 24'hFFFFFF, 0};
    vecs[9]  = '{4'b0011, 2'd0, 24'h000001, 1};
    vecs[10] = '{4'b0011, 2'd1, 24'h800000, 4};

    // Reset state
    do_reset();
    check("reset ch_ready", ch_ready, 0);
    check("reset fir_din_valid", fir_din_valid, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset dout", dout, 0);
    check("reset err", err, 0);

    // Round-robin transaction table
    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_grant(vecs[i].valid, vecs[i].exp_ch, tag);
      feed_filter(vecs[i].result, vecs[i].lat, vecs[i].exp_ch, tag);
      finish_txn(tag);
    end

    // Backpressure: result held 50 cycles with other requests pending
    start_grant(4'b0110, 2'd2, "hold");
    feed_filter(24'h13579B, 0, 2'd2, "hold");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dout_valid !== 1'b1 || dout !== 24'h13579B || dout_ch !== 2'd2 ||
          ch_ready !== 4'b0 || err !== 1'b0) bad++;
    end
    check("hold stable cycles", bad, 0);
    finish_txn("hold");

    // Watchdog expiry with TIMEOUT=16: filter never takes the sample
    do_reset();
    ch_valid = 4'b0001;
    @(negedge clk);
    check("wd grant", wd_ch_ready, 4'b0001);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (wd_err !== 1'b0 || wd_fir_rst !== 1'b0) bad++;
    end
    check("wd no early err", bad, 0);
    ch_valid = 4'b0011;
    @(negedge clk);
    check("wd err pulse", wd_err, 1);
    check("wd fir_rst pulse", wd_fir_rst, 1);
    check("wd no delivery", wd_dout_valid, 0);
    check("wd din_valid drop", wd_fir_din_valid, 0);
    check("wd no grant on expiry", wd_ch_ready, 0);
    @(negedge clk);
    check("wd err width", wd_err, 0);
    check("wd fir_rst width", wd_fir_rst, 0);
    check("wd next grant", wd_ch_ready, 4'b0010);
    $display("txn watchdog ch=0 err observed=%0d", 1);

    // Result arrives on the expiry cycle: result wins
    do_reset();
    ch_valid = 4'b0001;
    fir_dout = 24'h0BEEF0;
    @(negedge clk);
    check("race grant", wd_ch_ready, 4'b0001);
    ch_valid = 4'b0000;
    fir_ready_in = 1'b1;
    @(negedge clk);
    fir_ready_in = 1'b0;
    repeat (14) @(negedge clk);
    fir_dout_valid = 1'b1;
    @(negedge clk);
    fir_dout_valid = 1'b0;
    check("race no err", wd_err, 0);
    check("race no fir_rst", wd_fir_rst, 0);
    check("race fir_ready", wd_fir_ready, 1);
    check("race dout_valid", wd_dout_valid, 1);
    check("race dout", wd_dout, 24'h0BEEF0);
    repeat (20) @(negedge clk);
    check("race deliver no err", wd_err, 0);
    check("race deliver held", wd_dout_valid, 1);
    $display("txn race ch=%0d dout=0x%06h", wd_dout_ch, wd_dout);

    // Reset during WAIT aborts and restores channel 0 priority start
    do_reset();
    start_grant(4'b0100, 2'd2, "pre");
    feed_filter(24'h00C0DE, 1, 2'd2, "pre");
    finish_txn("pre");
    start_grant(4'b0001, 2'd0, "abort");
    fir_ready_in = 1'b1;
    @(negedge clk);
    fir_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ch_valid = 4'b1100;
    fir_dout = 24'h777777;
    fir_dout_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fir_dout_valid = 1'b0;
    check("abort ch_ready", ch_ready, 0);
    check("abort fir_din_valid", fir_din_valid, 0);
    check("abort fir_din", fir_din, 0);
    check("abort fir_ch", fir_ch, 0);
    check("abort fir_ready", fir_ready_out, 0);
    check("abort fir_rst", fir_rst, 0);
    check("abort dout", dout, 0);
    check("abort dout_ch", dout_ch, 0);
    check("abort dout_valid", dout_valid, 0);
    check("abort err", err, 0);
    $display("txn abort ch=0 dout_valid=%0d", dout_valid);
    start_grant(4'b1100, 2'd2, "post");
    feed_filter(24'h0000AA, 2, 2'd2, "post");
    finish_txn("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
